// File: rtl/mem_arbiter.sv
// Round-robin arbiter: IF and LS share one registered memory port.
// Ports: if_*/ls_* masters, mem_* memory side, hold_o stall, bus_err_o timeout.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                ls_ack_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i,
  output logic                hold_o,
  output logic                bus_err_o
);

  localparam int MW = DATA_W / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e              state_q;
  logic                gnt_ls_q;
  logic                gnt_ls_d;
  logic [CW-1:0]       cnt_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MW-1:0]       mem_wmask_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   ls_rdata_q;
  logic                if_ack_q;
  logic                ls_ack_q;
  logic                err_q;

  // LS wins when alone, or on a tie when IF was granted last.
  always_comb begin
    gnt_ls_d = ls_req_i & (~if_req_i | ~gnt_ls_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_ls_q    <= 1'b1;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      ls_ack_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (if_req_i || ls_req_i) begin
            state_q   <= S_BUSY;
            gnt_ls_q  <= gnt_ls_d;
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            if (gnt_ls_d) begin
              mem_we_q    <= ls_we_i;
              mem_addr_q  <= ls_addr_i;
              mem_wdata_q <= ls_wdata_i;
              mem_wmask_q <= ls_wmask_i;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr_i;
              mem_wdata_q <= '0;
              mem_wmask_q <= '0;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_DONE;
            if_ack_q  <= ~gnt_ls_q;
            ls_ack_q  <= gnt_ls_q;
            if (gnt_ls_q) ls_rdata_q <= mem_rdata_i;
            else          if_rdata_q <= mem_rdata_i;
          end else if (cnt_q == CNT_LAST) begin
            // Abort: give the master a zero result and flag the error.
            mem_req_q <= 1'b0;
            state_q   <= S_DONE;
            err_q     <= 1'b1;
            if_ack_q  <= ~gnt_ls_q;
            ls_ack_q  <= gnt_ls_q;
            if (gnt_ls_q) ls_rdata_q <= '0;
            else          if_rdata_q <= '0;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wmask_o = mem_wmask_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign ls_ack_o    = ls_ack_q;
  assign bus_err_o   = err_q;
  assign hold_o      = ls_req_i & ~ls_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Covers reads, stores, round-robin, timeout, async reset and stray acks.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic [3:0]  ls_wmask_i;
  logic [31:0] ls_rdata_o;
  logic        ls_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        hold_o;
  logic        bus_err_o;

  int n_chk;
  int n_err;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req_i(if_req_i),
    .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o),
    .if_ack_o(if_ack_o),
    .ls_req_i(ls_req_i),
    .ls_we_i(ls_we_i),
    .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i),
    .ls_wmask_i(ls_wmask_i),
    .ls_rdata_o(ls_rdata_o),
    .ls_ack_o(ls_ack_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i),
    .hold_o(hold_o),
    .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    if_req_i = 0; if_addr_i = 0;
    ls_req_i = 0; ls_we_i = 0; ls_addr_i = 0;
    ls_wdata_i = 0; ls_wmask_i = 0;
    mem_rdata_i = 0; mem_ack_i = 0;
    #23;
    check("rst_mem_req", 32'(mem_req_o), 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_if_rdata", if_rdata_o, 0);
    check("rst_ack", {30'd0, if_ack_o, ls_ack_o}, 0);
    check("rst_err", 32'(bus_err_o), 0);
    rst_n = 1'b1;
    step();

    // IF read, k=1
    if_req_i = 1; if_addr_i = 32'h100;
    step();
    check("if_req_c1", 32'(mem_req_o), 1);
    check("if_we_c1", 32'(mem_we_o), 0);
    check("if_addr_c1", mem_addr_o, 32'h100);
    mem_ack_i = 1; mem_rdata_i = 32'h13;
    step();
    mem_ack_i = 0; if_req_i = 0;
    check("if_ack_c2", 32'(if_ack_o), 1);
    check("if_rdata_c2", if_rdata_o, 32'h13);
    check("if_lsack_c2", 32'(ls_ack_o), 0);
    check("if_memreq_c2", 32'(mem_req_o), 0);
    step();
    check("if_ack_c3", 32'(if_ack_o), 0);

    // LS store, k=3
    ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h2000_0004;
    ls_wdata_i = 32'hDEAD_BEEF; ls_wmask_i = 4'hF;
    #1 check("st_hold_c0", 32'(hold_o), 1);
    for (int c = 1; c <= 3; c++) begin
      step();
      check("st_req", 32'(mem_req_o), 1);
      check("st_we", 32'(mem_we_o), 1);
      check("st_addr", mem_addr_o, 32'h2000_0004);
      check("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      check("st_mask", 32'(mem_wmask_o), 32'hF);
      check("st_hold", 32'(hold_o), 1);
      check("st_noack", 32'(ls_ack_o), 0);
    end
    mem_ack_i = 1; mem_rdata_i = 32'h55;
    step();
    mem_ack_i = 0;
    check("st_ack_c4", 32'(ls_ack_o), 1);
    check("st_hold_c4", 32'(hold_o), 0);
    check("st_rdata_c4", ls_rdata_o, 32'h55);
    ls_req_i = 0; ls_we_i = 0; ls_wmask_i = 0;
    step();

    // Simultaneous requests from reset: IF, LS, IF, LS
    rst_n = 0; #3; rst_n = 1;
    step();
    if_req_i = 1; if_addr_i = 32'h40;
    ls_req_i = 1; ls_addr_i = 32'h80;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_req", 32'(mem_req_o), 1);
      check("rr_addr", mem_addr_o, (i % 2 == 0) ? 32'h40 : 32'h80);
      mem_ack_i = 1; mem_rdata_i = 32'h100 + i;
      step();
      mem_ack_i = 0;
      check("rr_ifack", 32'(if_ack_o), (i % 2 == 0) ? 1 : 0);
      check("rr_lsack", 32'(ls_ack_o), (i % 2 == 0) ? 0 : 1);
      if (i == 3) begin
        if_req_i = 0; ls_req_i = 0;
      end
      step();
      check("rr_idle", 32'(mem_req_o), 0);
    end
    check("rr_if_rdata", if_rdata_o, 32'h102);
    check("rr_ls_rdata", ls_rdata_o, 32'h103);

    // Timeout on LS load
    ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h300;
    for (int c = 1; c <= 8; c++) begin
      step();
      check("to_req", 32'(mem_req_o), 1);
      check("to_noerr", 32'(bus_err_o), 0);
    end
    step();
    check("to_ack", 32'(ls_ack_o), 1);
    check("to_err", 32'(bus_err_o), 1);
    check("to_rdata", ls_rdata_o, 0);
    check("to_req_c9", 32'(mem_req_o), 0);
    ls_req_i = 0;
    if_req_i = 1; if_addr_i = 32'h500;
    step();
    check("to_err_c10", 32'(bus_err_o), 0);
    check("to_ack_c10", 32'(ls_ack_o), 0);
    step();
    check("to_idle_grant", mem_addr_o, 32'h500);
    check("to_idle_req", 32'(mem_req_o), 1);
    mem_ack_i = 1; mem_rdata_i = 32'h77;
    step();
    mem_ack_i = 0; if_req_i = 0;
    check("to_if_rdata", if_rdata_o, 32'h77);
    step();

    // Reset in the middle of a BUSY cycle
    ls_req_i = 1; ls_addr_i = 32'h600;
    step();
    check("mr_busy", 32'(mem_req_o), 1);
    #2 rst_n = 0;
    #1;
    check("mr_req", 32'(mem_req_o), 0);
    check("mr_addr", mem_addr_o, 0);
    check("mr_if_rdata", if_rdata_o, 0);
    ls_req_i = 0;
    step();
    #2 rst_n = 1;
    if_req_i = 1; if_addr_i = 32'h700;
    ls_req_i = 1; ls_addr_i = 32'h800;
    step();
    check("mr_tie_if", mem_addr_o, 32'h700);
    mem_ack_i = 1; mem_rdata_i = 32'h99;
    step();
    mem_ack_i = 0;
    if_req_i = 0; ls_req_i = 0;
    check("mr_ifack", 32'(if_ack_o), 1);
    step();

    // Stray ack in IDLE
    mem_ack_i = 1; mem_rdata_i = 32'hBAD;
    step();
    mem_ack_i = 0;
    check("sa_idle_ack", {30'd0, if_ack_o, ls_ack_o}, 0);
    check("sa_idle_rdata", if_rdata_o, 32'h99);
    check("sa_idle_req", 32'(mem_req_o), 0);
    // Stray ack in DONE
    if_req_i = 1; if_addr_i = 32'h900;
    step();
    mem_ack_i = 1; mem_rdata_i = 32'h21;
    step();
    if_req_i = 0;
    mem_rdata_i = 32'hBAD;
    check("sa_done_ack", 32'(if_ack_o), 1);
    step();
    mem_ack_i = 0;
    check("sa_done_noack", {30'd0, if_ack_o, ls_ack_o}, 0);
    check("sa_done_rdata", if_rdata_o, 32'h21);
    check("sa_done_req", 32'(mem_req_o), 0);
    step();
    check("sa_idle_after", 32'(mem_req_o), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
